// File: rtl/frame_bank_ctrl.sv
// Double-buffer frame writer: stores the rotated pixel stream into one of two BRAM banks and
// swaps banks with the display reader. Define FRAME_BANK_CTRL_STATS_EN to enable drop/error counters.
module frame_bank_ctrl #(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned PIX_ADDR_W   = 17,
  parameter int unsigned BRAM_ADDR_W  = 18,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                   cam_clk_in,
  input  logic                   rst_n_in,
  input  logic                   valid_pixel_in,
  input  logic [15:0]            pixel_in,
  input  logic [PIX_ADDR_W-1:0]  pixel_addr_in,
  input  logic                   frame_done_in,
  input  logic                   read_release_in,
  output logic                   bram_we_out,
  output logic [BRAM_ADDR_W-1:0] bram_addr_out,
  output logic [15:0]            bram_din_out,
  output logic                   read_bank_out,
  output logic                   frame_swap_out,
  output logic                   frame_err_out,
  output logic [CNT_W-1:0]       dropped_frames_out,
  output logic [CNT_W-1:0]       err_frames_out
);

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [PIX_ADDR_W-1:0]  CNT_FULL = PIX_ADDR_W'(FRAME_PIXELS);
  localparam logic [PIX_ADDR_W-1:0]  CNT_OVER = PIX_ADDR_W'(FRAME_PIXELS + 1);
  localparam logic [BRAM_ADDR_W-1:0] BANK_OFS = BRAM_ADDR_W'(FRAME_PIXELS);

  logic [1:0]             state_q, state_d;
  logic                   write_bank_q, write_bank_d;
  logic [PIX_ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic                   reader_free_q, reader_free_d;
  logic                   we_q, we_d;
  logic [BRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]            din_q, din_d;
  logic                   swap_q, swap_d;
  logic                   err_q, err_d;
  logic                   free_now;
  logic                   swap_now;
  logic [BRAM_ADDR_W-1:0] bank_base;

  // A release arriving in the same cycle as the decision counts immediately.
  assign free_now  = reader_free_q | read_release_in;
  assign bank_base = write_bank_q ? BANK_OFS : '0;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    reader_free_d = free_now;
    we_d          = 1'b0;
    addr_d        = addr_q;
    din_d         = din_q;
    err_d         = 1'b0;
    swap_now      = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (frame_done_in) begin
          state_d   = ST_CAPTURE;
          pix_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (frame_done_in) begin
          pix_cnt_d = '0;
          if (pix_cnt_q == CNT_FULL) begin
            if (free_now) swap_now = 1'b1;
            else          state_d  = ST_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else if (valid_pixel_in) begin
          if (pix_cnt_q < CNT_FULL) begin
            we_d   = 1'b1;
            addr_d = BRAM_ADDR_W'(pixel_addr_in) + bank_base;
            din_d  = pixel_in;
          end
          if (pix_cnt_q != CNT_OVER) pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (free_now) begin
          swap_now = 1'b1;
          state_d  = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    write_bank_d = swap_now ? ~write_bank_q : write_bank_q;
    swap_d       = swap_now;
    if (swap_now) reader_free_d = 1'b0;
  end

  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_SYNC;
      write_bank_q  <= 1'b0;
      pix_cnt_q     <= '0;
      reader_free_q <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      swap_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_bank_q  <= write_bank_d;
      pix_cnt_q     <= pix_cnt_d;
      reader_free_q <= reader_free_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      swap_q        <= swap_d;
      err_q         <= err_d;
    end
  end

  assign bram_we_out    = we_q;
  assign bram_addr_out  = addr_q;
  assign bram_din_out   = din_q;
  assign read_bank_out  = ~write_bank_q;
  assign frame_swap_out = swap_q;
  assign frame_err_out  = err_q;

`ifdef FRAME_BANK_CTRL_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             drop_inc;

  assign drop_inc = (state_q == ST_HOLD) && frame_done_in && !free_now;

  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (err_d && (err_cnt_q != '1))     err_cnt_q  <= err_cnt_q + 1'b1;
    end
  end

  assign dropped_frames_out = drop_cnt_q;
  assign err_frames_out     = err_cnt_q;
`else
  assign dropped_frames_out = '0;
  assign err_frames_out     = '0;
`endif

  // A swap only follows a good frame, an error only a bad one.
  a_swap_err_excl: assert property (@(posedge cam_clk_in) disable iff (!rst_n_in)
    !(frame_swap_out && frame_err_out));
  a_addr_range: assert property (@(posedge cam_clk_in) disable iff (!rst_n_in)
    bram_we_out |-> (bram_addr_out < BRAM_ADDR_W'(2 * FRAME_PIXELS)));

endmodule
